// File: rtl/sump3_rle_capture.sv
// rtl/sump3_rle_capture.sv - parametrised RLE capture engine with pattern trigger and ring buffer
//
// Purpose:
//   Captures an events vector into an on-chip ring RAM as run-length records
//   {code, timestamp, data}. A record is written on the first armed cycle,
//   on every change of the registered events, on a trigger, and on timestamp
//   rollover. After the trigger, post_trig_len more records are written and
//   the engine stops in DONE.
//
// Ports:
//   clk_cap     capture clock, rising edge
//   reset_n     asynchronous active-low reset
//   arm         single-cycle pulse, restarts capture from any state
//   trig_ext    external level trigger, evaluated in ARMED
//   trig_mask   per-bit enable for the pattern trigger
//   trig_match  pattern value for the masked bits
//   events      signals to capture
//   rd_addr     RAM read address
//   rd_data     registered RAM read data {code, timestamp, data}
//   state       0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   trig_addr   RAM address of the trigger record
//   wr_addr     next write address (oldest record once wrapped)
//   wrapped     ring wrapped at least once since arm
//   done        high in DONE

module sump3_rle_capture #(
  parameter int data_bits      = 8,
  parameter int timestamp_bits = 26,
  parameter int depth_bits     = 10,
  parameter int post_trig_len  = 512
) (
  input  logic                                   clk_cap,
  input  logic                                   reset_n,
  input  logic                                   arm,
  input  logic                                   trig_ext,
  input  logic [data_bits-1:0]                   trig_mask,
  input  logic [data_bits-1:0]                   trig_match,
  input  logic [data_bits-1:0]                   events,
  input  logic [depth_bits-1:0]                  rd_addr,
  output logic [2+timestamp_bits+data_bits-1:0]  rd_data,
  output logic [1:0]                             state,
  output logic [depth_bits-1:0]                  trig_addr,
  output logic [depth_bits-1:0]                  wr_addr,
  output logic                                   wrapped,
  output logic                                   done
);

  localparam int REC_BITS = 2 + timestamp_bits + data_bits;
  localparam logic [depth_bits-1:0] POST_LAST = depth_bits'(post_trig_len - 1);

  localparam logic [1:0] CODE_PRE  = 2'b01;
  localparam logic [1:0] CODE_TRIG = 2'b10;
  localparam logic [1:0] CODE_POST = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [data_bits-1:0]      ev_q, ev_prev_q;
  logic [timestamp_bits-1:0] ts_q, ts_d;
  logic [depth_bits-1:0]     wr_addr_q, wr_addr_d;
  logic [depth_bits-1:0]     trig_addr_q, trig_addr_d;
  logic [depth_bits-1:0]     post_cnt_q, post_cnt_d;
  logic                      wrapped_q, wrapped_d;
  logic                      first_q, first_d;
  logic [REC_BITS-1:0]       rd_data_q;

  logic                      we;
  logic [1:0]                wr_code;
  logic                      changed;
  logic                      ts_max;
  logic                      pat_hit;
  logic                      trig_hit;

  logic [REC_BITS-1:0]       mem [2**depth_bits];

  assign changed  = (ev_q != ev_prev_q);
  assign ts_max   = &ts_q;
  // An all-zero mask disables the pattern trigger instead of matching always.
  assign pat_hit  = (|trig_mask) && ((ev_q & trig_mask) == (trig_match & trig_mask));
  assign trig_hit = trig_ext || pat_hit;

  always_comb begin
    state_d     = state_q;
    ts_d        = ts_q;
    wr_addr_d   = wr_addr_q;
    trig_addr_d = trig_addr_q;
    wrapped_d   = wrapped_q;
    post_cnt_d  = post_cnt_q;
    first_d     = first_q;
    we          = 1'b0;
    wr_code     = CODE_PRE;

    if (arm) begin
      // arm overrides everything, including a trigger in the same cycle.
      state_d    = ST_ARMED;
      ts_d       = '0;
      wr_addr_d  = '0;
      wrapped_d  = 1'b0;
      post_cnt_d = '0;
      first_d    = 1'b1;
    end else begin
      case (state_q)
        ST_ARMED: begin
          ts_d    = ts_q + 1'b1;
          first_d = 1'b0;
          if (first_q) begin
            // Anchor record so the capture always starts from a known value.
            we      = 1'b1;
            wr_code = CODE_PRE;
          end else if (trig_hit) begin
            we          = 1'b1;
            wr_code     = CODE_TRIG;
            trig_addr_d = wr_addr_q;
            state_d     = ST_POST;
          end else if (changed || ts_max) begin
            we      = 1'b1;
            wr_code = CODE_PRE;
          end
        end
        ST_POST: begin
          ts_d = ts_q + 1'b1;
          if (changed || ts_max) begin
            we         = 1'b1;
            wr_code    = CODE_POST;
            post_cnt_d = post_cnt_q + 1'b1;
            if (post_cnt_q == POST_LAST) begin
              state_d = ST_DONE;
            end
          end
        end
        default: begin
        end
      endcase
    end

    if (we) begin
      wr_addr_d = wr_addr_q + 1'b1;
      if (&wr_addr_q) begin
        wrapped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_cap or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ev_q        <= '0;
      ev_prev_q   <= '0;
      ts_q        <= '0;
      wr_addr_q   <= '0;
      trig_addr_q <= '0;
      post_cnt_q  <= '0;
      wrapped_q   <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ev_q        <= events;
      ev_prev_q   <= ev_q;
      ts_q        <= ts_d;
      wr_addr_q   <= wr_addr_d;
      trig_addr_q <= trig_addr_d;
      post_cnt_q  <= post_cnt_d;
      wrapped_q   <= wrapped_d;
      first_q     <= first_d;
    end
  end

  // RAM is deliberately not reset; old content survives reset and re-arm.
  always_ff @(posedge clk_cap) begin
    if (we) begin
      mem[wr_addr_q] <= {wr_code, ts_q, ev_q};
    end
  end

  // Same-address read during a write returns the previous content.
  always_ff @(posedge clk_cap or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data   = rd_data_q;
  assign state     = state_q;
  assign trig_addr = trig_addr_q;
  assign wr_addr   = wr_addr_q;
  assign wrapped   = wrapped_q;
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_sump3_rle_capture.sv
// tb/tb_sump3_rle_capture.sv - directed self-checking bench for sump3_rle_capture

module tb_sump3_rle_capture;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       arm = 1'b0;
  logic       trig_ext = 1'b0;
  logic [7:0] trig_mask = 8'h00;
  logic [7:0] trig_match = 8'h00;
  logic [7:0] events = 8'h00;
  logic [9:0] rd_addr = '0;

  // DUT A: default widths, short post-trigger length.
  logic [35:0] rd_data_a;
  logic [1:0]  state_a;
  logic [9:0]  trig_addr_a, wr_addr_a;
  logic        wrapped_a, done_a;

  // DUT B: 4-bit timestamp and 16-entry ring.
  logic [13:0] rd_data_b;
  logic [1:0]  state_b;
  logic [3:0]  trig_addr_b, wr_addr_b;
  logic        wrapped_b, done_b;

  int n_checks = 0;
  int n_fail   = 0;
  int ts       = 0;

  always #5 clk = ~clk;

  sump3_rle_capture #(
    .data_bits(8), .timestamp_bits(26), .depth_bits(10), .post_trig_len(4)
  ) dut_a (
    .clk_cap(clk), .reset_n(reset_n), .arm(arm), .trig_ext(trig_ext),
    .trig_mask(trig_mask), .trig_match(trig_match), .events(events),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .state(state_a),
    .trig_addr(trig_addr_a), .wr_addr(wr_addr_a), .wrapped(wrapped_a), .done(done_a)
  );

  sump3_rle_capture #(
    .data_bits(8), .timestamp_bits(4), .depth_bits(4), .post_trig_len(4)
  ) dut_b (
    .clk_cap(clk), .reset_n(reset_n), .arm(arm), .trig_ext(trig_ext),
    .trig_mask(trig_mask), .trig_match(trig_match), .events(events),
    .rd_addr(rd_addr[3:0]), .rd_data(rd_data_b), .state(state_b),
    .trig_addr(trig_addr_b), .wr_addr(wr_addr_b), .wrapped(wrapped_b), .done(done_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ts++;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    ts = 0;
  endtask

  function automatic logic [35:0] rec_a(input logic [1:0] c, input int t, input logic [7:0] d);
    return {c, t[25:0], d};
  endfunction

  function automatic logic [13:0] rec_b(input logic [1:0] c, input int t, input logic [7:0] d);
    return {c, t[3:0], d};
  endfunction

  initial begin
    // Reset values
    repeat (3) step();
    check_eq("rst_state", state_a, 2'd0);
    check_eq("rst_wr_addr", wr_addr_a, 10'd0);
    check_eq("rst_trig_addr", trig_addr_a, 10'd0);
    check_eq("rst_wrapped", wrapped_a, 1'b0);
    check_eq("rst_done", done_a, 1'b0);
    check_eq("rst_rd_data", rd_data_a, 36'd0);
    reset_n = 1'b1;
    step();
    check_eq("idle_hold", state_a, 2'd0);

    // Static events: only the first-cycle record
    do_arm();
    repeat (10) step();
    check_eq("arm_state", state_a, 2'd1);
    check_eq("arm_wr_addr", wr_addr_a, 10'd1);
    rd_addr = 10'd0;
    step();
    check_eq("ram0_first", rd_data_a, rec_a(2'b01, 0, 8'h00));

    // Change at ts=20, pattern trigger at ts=30
    trig_mask  = 8'hFF;
    trig_match = 8'hA5;
    while (ts < 19) step();
    events = 8'h05;
    step();
    while (ts < 29) step();
    events = 8'hA5;
    step();
    events = 8'h5A;
    step();
    check_eq("trig_state", state_a, 2'd2);
    check_eq("trig_addr", trig_addr_a, 10'd2);
    check_eq("trig_addr_b_rollover", trig_addr_b, 4'd3);
    events = 8'hA5; step();
    events = 8'h5A; step();
    events = 8'hA5; step();
    events = 8'h5A; step();
    check_eq("post_done_state", state_a, 2'd3);
    check_eq("post_done_flag", done_a, 1'b1);
    check_eq("post_wr_addr", wr_addr_a, 10'd7);
    for (int i = 0; i < 3; i++) begin
      events = ~events;
      step();
    end
    check_eq("done_no_write", wr_addr_a, 10'd7);
    rd_addr = 10'd1; step();
    check_eq("ram1_change", rd_data_a, rec_a(2'b01, 20, 8'h05));
    rd_addr = 10'd2; step();
    check_eq("ram2_trig", rd_data_a, rec_a(2'b10, 30, 8'hA5));
    rd_addr = 10'd3; step();
    check_eq("ram3_post", rd_data_a, rec_a(2'b11, 31, 8'h5A));
    rd_addr = 10'd6; step();
    check_eq("ram6_post", rd_data_a, rec_a(2'b11, 34, 8'hA5));

    // Timestamp rollover records on the 4-bit instance
    trig_mask  = 8'h00;
    trig_match = 8'h00;
    events     = 8'h33;
    do_arm();
    while (ts < 40) step();
    check_eq("roll_wr_addr_b", wr_addr_b, 4'd3);
    check_eq("roll_wr_addr_a", wr_addr_a, 10'd1);
    rd_addr = 10'd1; step();
    check_eq("roll_rec1_b", rd_data_b, rec_b(2'b01, 15, 8'h33));
    rd_addr = 10'd2; step();
    check_eq("roll_rec2_b", rd_data_b, rec_b(2'b01, 15, 8'h33));

    // Ring wrap on the 16-entry instance, then external trigger
    events = 8'd1;
    do_arm();
    for (int k = 1; k < 20; k++) begin
      events = 8'(k + 1);
      step();
    end
    step();
    check_eq("wrap_flag_b", wrapped_b, 1'b1);
    check_eq("wrap_wr_addr_b", wr_addr_b, 4'd4);
    check_eq("nowrap_wr_addr_a", wr_addr_a, 10'd20);
    trig_ext = 1'b1;
    step();
    trig_ext = 1'b0;
    check_eq("ext_trig_addr_b", trig_addr_b, 4'd4);
    check_eq("ext_state_b", state_b, 2'd2);
    check_eq("ext_trig_addr_a", trig_addr_a, 10'd20);
    rd_addr = 10'd4; step();
    check_eq("ext_trig_rec_b", rd_data_b, rec_b(2'b10, 20, 8'd20));

    // arm mid-POST, read-during-write of address 0
    rd_addr = 10'd0;
    events  = 8'h77;
    do_arm();
    check_eq("rearm_state", state_b, 2'd1);
    check_eq("rearm_wr_addr_b", wr_addr_b, 4'd0);
    check_eq("rearm_wrapped_b", wrapped_b, 1'b0);
    step();
    check_eq("rdw_old_data", rd_data_a, rec_a(2'b01, 0, 8'h01));
    step();
    check_eq("rearm_ts_zero", rd_data_a, rec_a(2'b01, 0, 8'h77));

    // Asynchronous reset mid-ARMED
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("areset_state", state_a, 2'd0);
    check_eq("areset_wr_addr", wr_addr_a, 10'd0);
    check_eq("areset_trig_addr", trig_addr_a, 10'd0);
    check_eq("areset_rd_data", rd_data_a, 36'd0);
    check_eq("areset_trig_addr_b", trig_addr_b, 4'd0);
    check_eq("areset_done_b", done_b, 1'b0);
    step();
    reset_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sump3_rle_capture.md
Name: sump3_rle_capture

Overview:
- Parametrised, self-contained RLE capture engine for one clock domain.
- Generalises the fixed 8-bit/26-bit pod records to any event width, timestamp width and depth.
- Adds an on-chip pattern trigger with mask, pre/post-trigger ring buffering, explicit timestamp-rollover records and a direct RAM read port, with no hub serial link.
- Sits beside the capture logic; a local control FSM or CPU drives arm and reads results.

Parameters:
data_bits, 8, width of events vector
timestamp_bits, 26, width of free-running timestamp stored per record
depth_bits, 10, log2 of RAM depth; depth = 2**depth_bits records
post_trig_len, 512, records written after the trigger record; must be < 2**depth_bits - 1

Ports:
clk_cap  in  1  capture clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
arm  in  1  single-cycle pulse; clears and starts capture from any state
trig_ext  in  1  external trigger, level, sampled in ARMED
trig_mask  in  data_bits  1 = bit participates in pattern trigger
trig_match  in  data_bits  pattern value for masked bits
events  in  data_bits  signals to capture
rd_addr  in  depth_bits  RAM read address
rd_data  out  2+timestamp_bits+data_bits  record {code,timestamp,data}; registered
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
trig_addr  out  depth_bits  RAM address of trigger record
wr_addr  out  depth_bits  next write address; oldest record when wrapped
wrapped  out  1  ring wrapped at least once since arm
done  out  1  high in DONE

Behaviour:
- Reset values: state=IDLE, trig_addr=0, wr_addr=0, wrapped=0, done=0, rd_data=0, timestamp=0. RAM contents are not reset.
- events is registered once (ev_q) internally; all compare and record logic uses ev_q and ev_q_prev.
- Record codes:
  - 01 pre-trigger sample
  - 10 trigger
  - 11 post-trigger sample
  - 00 never written
- IDLE -> ARMED on arm. Also clears timestamp, wr_addr, wrapped and post counter.
- ARMED:
  - First cycle always writes code 01 with the current ev_q.
  - Afterwards, write code 01 when ev_q != ev_q_prev.
  - wr_addr increments per write, wrapping 2**depth_bits-1 -> 0 and setting wrapped.
- Trigger condition: trig_ext, or (mask != 0 and (ev_q & mask) == (trig_match & mask)).
  - Evaluated only from the second ARMED cycle onward.
  - On the condition: write code 10 with ev_q regardless of change, latch trig_addr=wr_addr, go to POST next cycle.
- POST: write code 11 on change. After post_trig_len code-11/rollover writes, go to DONE. No write occurs in the DONE cycle.
- Timestamp:
  - Counts +1 per cycle in ARMED and POST; holds in IDLE and DONE.
  - When timestamp == all-ones and no other write is due, write a rollover record with the current phase code (01 in ARMED, 11 in POST) and the current ev_q.
  - The counter then wraps to 0.
- Write collision priority: trigger > change > rollover. Exactly one record is written per cycle at most.
- arm in any state, including mid-POST, restarts as from IDLE on the next cycle; prior RAM content is treated as stale.
- arm coincident with a trigger condition: arm wins.
- reset_n low mid-capture: immediate return to reset values; RAM is untouched.
- Read port:
  - rd_data = RAM[rd_addr], 1-cycle latency, usable in every state.
  - Reading the address being written in the same cycle returns old data.
- Widths: RAM width = 2+timestamp_bits+data_bits (36 at defaults). Counters wrap modulo their width, with no saturation.

Test Plan:
- Reset, arm, hold events=8'h00 for 10 cycles: RAM[0]={01,ts=0,00}; no other writes; state=1; wr_addr=1.
- Armed, events 00->05 at ts=20, trig_mask=FF, trig_match=A5, events->A5 at ts=30:
  - RAM[1]={01,20,05} and RAM[2]={10,30,A5}.
  - trig_addr=2, state=2 on the next cycle.
- post_trig_len=4, toggle events every cycle after trigger:
  - exactly 4 code-11 records at addresses 3..6.
  - state=3, done=1; further toggles write nothing.
- timestamp_bits=4, static events in ARMED: rollover record {01,15,data} every 16 cycles.
- depth_bits=4, change every cycle for 20 cycles before trigger:
  - wrapped=1, wr_addr=4.
  - trig_ext then writes the trigger record at address 4.
- arm asserted mid-POST: state=1 next cycle, wr_addr=0, wrapped=0, timestamp=0; reset_n low mid-ARMED returns all outputs to reset values.
